// File: rtl/chip8_pkg.sv
// Shared CHIP-8 constants and the draw sequencer state type.
//   DISP_W/DISP_H   : display geometry in pixels
//   ADDR_W          : memory address width (4 KiB address space)
//   MEM_LAT_DEFAULT : default cycles from mem_rd to valid mem_rdata
//   seq_state_t     : draw sequencer states
package chip8_pkg;

    localparam int DISP_W          = 64;
    localparam int DISP_H          = 32;
    localparam int ADDR_W          = 12;
    localparam int MEM_LAT_DEFAULT = 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        DRAW,
        DONE
    } seq_state_t;

endpackage

// File: rtl/chip8_draw_sequencer.sv
// Sequences one CHIP-8 DXYN sprite draw: latches the operands on start,
// fetches N sprite bytes from memory starting at I, hands each row to the
// display and accumulates the per-row collision into VF.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               one-cycle request, sampled only in IDLE
//   vx, vy, n, i_reg    DXYN operands (X, Y register values, height, base)
//   busy, done, vf_flag status towards the CPU
//   mem_rd, mem_addr    memory read request
//   mem_rdata           read data, valid MEM_LAT cycles after mem_rd
//   draw, x, y,         one-cycle row strobe and row description
//   row_index,
//   sprite_data
//   collision           display collision for the row being drawn
module chip8_draw_sequencer
    import chip8_pkg::*;
#(
    parameter int MEM_LAT   = MEM_LAT_DEFAULT,
    parameter bit CLIP_ROWS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        vx,
    input  logic [7:0]        vy,
    input  logic [3:0]        n,
    input  logic [ADDR_W-1:0] i_reg,
    output logic              busy,
    output logic              done,
    output logic              vf_flag,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              draw,
    output logic [5:0]        x,
    output logic [4:0]        y,
    output logic [3:0]        row_index,
    output logic [7:0]        sprite_data,
    input  logic              collision
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    seq_state_t        state;
    logic [4:0]        y0;
    logic [3:0]        n_q;
    logic [ADDR_W-1:0] i_q;
    logic [3:0]        r;
    logic [CNT_W-1:0]  wait_cnt;

    logic [4:0]        r_next;
    logic [5:0]        y_next;
    logic              last_row;
    logic              clip_next;
    logic [ADDR_W-1:0] addr_next;

    // Upper operand bits are discarded by the mod-64 / mod-32 latch.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{vx[7:6], vy[7:5]};

    always_comb begin
        r_next    = {1'b0, r} + 5'd1;
        y_next    = {1'b0, y0} + {1'b0, r_next};
        last_row  = (r_next == {1'b0, n_q});
        // Row 0 can never clip since y0 < 32; only later rows are tested.
        clip_next = CLIP_ROWS && (y_next > 6'd31);
        addr_next = i_q + {{(ADDR_W-4){1'b0}}, r} + ADDR_W'(1);
    end

    // Outputs are set on the transition into the state that owns them, so
    // they are registered and aligned with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            y0          <= '0;
            n_q         <= '0;
            i_q         <= '0;
            r           <= '0;
            wait_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            vf_flag     <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            draw        <= 1'b0;
            x           <= '0;
            y           <= '0;
            row_index   <= '0;
            sprite_data <= '0;
        end else begin
            mem_rd <= 1'b0;
            draw   <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x       <= vx[5:0];
                        y0      <= vy[4:0];
                        n_q     <= n;
                        i_q     <= i_reg;
                        r       <= '0;
                        vf_flag <= 1'b0;
                        busy    <= 1'b1;
                        if (n == 4'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            mem_rd   <= 1'b1;
                            mem_addr <= i_reg;
                        end
                    end
                end
                FETCH: begin
                    if (MEM_LAT == 1) begin
                        sprite_data <= mem_rdata;
                        state       <= DRAW;
                        draw        <= 1'b1;
                        y           <= y0 + {1'b0, r};
                        row_index   <= r;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= CNT_W'(MEM_LAT - 2);
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        sprite_data <= mem_rdata;
                        state       <= DRAW;
                        draw        <= 1'b1;
                        y           <= y0 + {1'b0, r};
                        row_index   <= r;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DRAW: begin
                    vf_flag <= vf_flag | collision;
                    r       <= r_next[3:0];
                    if (last_row || clip_next) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= FETCH;
                        mem_rd   <= 1'b1;
                        mem_addr <= addr_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
